apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that turns a simple valid/ready command port into APB SETUP/ACCESS transfers. It pairs with the `apb` register slave that fronts the I2C core, and it is the block that drives PSELx/PENABLE/PWRITE/PADDR/PWDATA toward it. It returns PRDATA and PSLVERR on a one-cycle response strobe. It can also abort transfers whose PREADY never arrives.

## Interface
- ADDR_W, 32, PADDR / CMD_ADDR width
- DATA_W, 32, PWDATA / PRDATA / command and response data width
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit in cycles (used only with APB_MASTER_TIMEOUT_EN; legal range 2..65535)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; synchronous and active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted on a cycle with CMD_VALID & CMD_READY
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_W  transfer address
- CMD_WDATA  in  DATA_W  write data
- RSP_VALID  out  1  one-cycle completion strobe
- RSP_RDATA  out  DATA_W  read data; 0 for writes and timeouts
- RSP_ERROR  out  1  PSLVERR captured, or timeout
- RSP_TIMEOUT  out  1  transfer aborted by timeout
- PSELx, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB wait control
- PSLVERR  in  1  APB slave error

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. All outputs are registered.
- IDLE:
  - CMD_READY=1, PSELx=0, PENABLE=0.
  - On CMD_VALID the block captures CMD_WRITE, CMD_ADDR and CMD_WDATA into PWRITE, PADDR and PWDATA, then moves to SETUP.
- SETUP: PSELx=1, PENABLE=0, CMD_READY=0. It always moves to ACCESS after one cycle.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - While PREADY=0 the block stays in ACCESS and holds PADDR, PWDATA and PWRITE stable.
  - When PREADY=1 the block returns to IDLE and issues RSP_VALID=1 for one cycle.
  - RSP_RDATA = PRDATA if the transfer is a read, else 0.
  - RSP_ERROR = PSLVERR.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY=1. They are ignored at all other times.
- Only one transfer is outstanding at a time. CMD_* are ignored while CMD_READY=0.
- PADDR, PWDATA and PWRITE keep their last values in IDLE. They change only on command acceptance.
- RSP_RDATA, RSP_ERROR and RSP_TIMEOUT hold their values until the next RSP_VALID.
- Reset:
  - Every output resets to 0, except CMD_READY, which resets to 1. State resets to IDLE.
  - A PRESET during SETUP or ACCESS aborts the transfer. PSELx and PENABLE are 0 in the cycle after the reset edge, and no response is issued.

## Timing
- Command accepted at edge N:
  - SETUP during cycle N..N+1.
  - ACCESS from edge N+1.
  - With zero wait states, PREADY=1 is sampled at edge N+2.
  - RSP_VALID=1 during cycle N+2..N+3, with CMD_READY=1 in the same cycle.
- Minimum latency from acceptance to RSP_VALID is 2 cycles. Each wait state (PREADY=0 in ACCESS) adds 1 cycle.
- Maximum throughput is one transfer per 3 cycles.
- A command presented in the RSP_VALID cycle is accepted in that cycle.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle in which PREADY=0 is sampled.
  - If PREADY is still 0 on the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts: return to IDLE, PSELx=PENABLE=0.
  - The abort response is RSP_VALID=1, RSP_TIMEOUT=1, RSP_ERROR=1, RSP_RDATA=0.
  - If PREADY=1 arrives on that same cycle, the normal completion wins.
- Undefined:
  - No counter is built, and ACCESS waits for PREADY indefinitely.
  - RSP_TIMEOUT is tied to 0.

## Test plan
- Zero-wait write: CMD write to 0x0000_0004 with data 0x0000_3A5C, PREADY=1.
  - Expect PSELx high for 2 cycles, PENABLE high for 1 cycle.
  - Expect PADDR=0x4, PWDATA=0x3A5C, PWRITE=1.
  - Expect RSP_VALID 2 cycles after acceptance with RSP_ERROR=0 and RSP_RDATA=0.
- Wait-state read: CMD read from 0x8, PREADY low for 3 ACCESS cycles, then PRDATA=0xDEAD_BEEF with PREADY=1.
  - Expect PADDR held at 0x8 throughout.
  - Expect RSP_VALID 5 cycles after acceptance with RSP_RDATA=0xDEADBEEF.
- Slave error: read with PSLVERR=1 on the PREADY cycle → RSP_ERROR=1, RSP_TIMEOUT=0. Also pulse PSLVERR=1 while PREADY=0 → no effect on the response.
- Back-to-back: hold CMD_VALID high with two commands.
  - Expect the second command accepted in the first command's RSP_VALID cycle.
  - Expect the next PSELx rise one cycle later, giving 3-cycle spacing.
- Reset mid-ACCESS: assert PRESET for 1 cycle while PREADY=0.
  - Expect PSELx=PENABLE=0 the next cycle and no RSP_VALID.
  - Expect CMD_READY=1 and a new command to complete normally.
- Timeout (macro defined, TIMEOUT_CYCLES=4): hold PREADY=0.
  - Expect the abort on the 4th ACCESS cycle with RSP_VALID=1, RSP_TIMEOUT=1, RSP_ERROR=1, RSP_RDATA=0.
  - With the macro undefined, the same stimulus leaves the block in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
//   A valid/ready command port is turned into one APB SETUP/ACCESS transfer
//   at a time. Completion is reported on a one-cycle RSP_VALID strobe that
//   carries the read data, the slave error and (optionally) a timeout flag.
//
// Ports
//   PCLK, PRESET       clock (rising edge), synchronous active-high reset
//   CMD_VALID/READY    command handshake; CMD_WRITE/ADDR/WDATA captured on accept
//   RSP_VALID          one-cycle completion strobe
//   RSP_RDATA          read data (0 for writes and timeouts), held until next RSP
//   RSP_ERROR          PSLVERR captured, or timeout
//   RSP_TIMEOUT        transfer aborted because PREADY never arrived
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA   APB requester outputs
//   PRDATA, PREADY, PSLVERR                 APB completer inputs
//
// Build option
//   APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase with PREADY low for
//                          TIMEOUT_CYCLES cycles is aborted. When undefined,
//                          ACCESS waits forever and RSP_TIMEOUT stays 0.
//
// Every output is a flop; the combinational process computes next values.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERROR,
  output logic              RSP_TIMEOUT,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state, state_nxt;
  logic                cmd_ready_nxt, rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
  logic                psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt, rsp_rdata_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counts ACCESS cycles that ended with PREADY low. On the last allowed
  // cycle it equals TIMEOUT_CYCLES-1.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         wait_cnt, wait_cnt_nxt;
`else
  logic                unused_timeout_param;
  assign unused_timeout_param = ^(16'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      CMD_READY   <= 1'b1;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERROR   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      CMD_READY   <= cmd_ready_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      RSP_RDATA   <= rsp_rdata_nxt;
      RSP_ERROR   <= rsp_error_nxt;
      RSP_TIMEOUT <= rsp_timeout_nxt;
      PSELx       <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    cmd_ready_nxt   = CMD_READY;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = RSP_RDATA;
    rsp_error_nxt   = RSP_ERROR;
    rsp_timeout_nxt = RSP_TIMEOUT;
    psel_nxt        = PSELx;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_nxt    = wait_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (CMD_VALID) begin
          state_nxt     = SETUP;
          cmd_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          pwrite_nxt    = CMD_WRITE;
          paddr_nxt     = CMD_ADDR;
          pwdata_nxt    = CMD_WDATA;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      ACCESS: begin
        // PREADY on the last allowed cycle still completes normally, so the
        // completion branch is checked before the timeout branch.
        if (PREADY) begin
          state_nxt       = IDLE;
          cmd_ready_nxt   = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_error_nxt   = PSLVERR;
          rsp_timeout_nxt = 1'b0;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_nxt       = IDLE;
          cmd_ready_nxt   = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_error_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master. Expected responses are queued when a command
// is driven and compared by a monitor whenever RSP_VALID is seen.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic        RSP_VALID, RSP_ERROR, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master #(.TIMEOUT_CYCLES(4)) dut (
`else
  apb_master dut (
`endif
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rsp_cnt = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge PCLK) begin
    if (RSP_VALID === 1'b1) begin
      rsp_t e;
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata",   RSP_RDATA,   e.rdata);
        chk("rsp_error",   RSP_ERROR,   e.err);
        chk("rsp_timeout", RSP_TIMEOUT, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer: waits = ACCESS cycles with PREADY low before the ready cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input logic slverr,
                      input logic slverr_in_wait);
    rsp_t e;
    int   acc;
    e.rdata = wr ? 32'h0 : rdata;
    e.err   = slverr;
    e.to    = 1'b0;
    sb.push_back(e);
    CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
    PREADY = (waits == 0); PSLVERR = slverr_in_wait; PRDATA = 32'hBAD0_0000;
    step();                                   // accept edge
    acc = cyc;
    CMD_VALID = 0; CMD_ADDR = 32'hFFFF_FFFF; CMD_WDATA = 32'hFFFF_FFFF; CMD_WRITE = ~wr;
    chk("setup_psel",    PSELx,   1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_ready",   CMD_READY, 0);
    chk("setup_paddr",   PADDR,   addr);
    chk("setup_pwdata",  PWDATA,  wdata);
    chk("setup_pwrite",  PWRITE,  wr);
    step();
    for (int i = 0; i < waits; i++) begin
      PREADY = 0; PSLVERR = slverr_in_wait;
      chk("wait_penable", PENABLE, 1);
      chk("wait_paddr",   PADDR,   addr);
      chk("wait_rsp",     RSP_VALID, 0);
      step();
    end
    PREADY = 1; PRDATA = rdata; PSLVERR = slverr;
    chk("access_penable", PENABLE, 1);
    step();
    PREADY = 0; PSLVERR = 1; PRDATA = 32'h5555_AAAA;
    chk("rsp_valid_latency", {RSP_VALID, 32'(cyc - acc)}, {1'b1, 32'(waits + 2)});
    chk("rsp_psel_low", PSELx, 0);
    chk("rsp_ready",    CMD_READY, 1);
    step();
    PSLVERR = 0;
    chk("rsp_one_shot",  RSP_VALID, 0);
    chk("rsp_hold_data", RSP_RDATA, e.rdata);
    chk("idle_paddr_hold", PADDR, addr);
  endtask

  initial begin
    rsp_t e;
    int   n;
    PRESET = 1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0;
    PRDATA = 0; PREADY = 0; PSLVERR = 0;
    step(); step();
    chk("rst_ready",   CMD_READY, 1);
    chk("rst_psel",    PSELx, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp",     RSP_VALID, 0);
    chk("rst_paddr",   PADDR, 0);
    chk("rst_pwrite",  PWRITE, 0);
    chk("rst_rsp_err", {RSP_ERROR, RSP_TIMEOUT}, 0);
    PRESET = 0;
    step();

    // Zero-wait write, wait-state read, slave errors
    xfer(1, 32'h0000_0004, 32'h0000_3A5C, 0, 32'h0,       0, 0);
    xfer(0, 32'h0000_0008, 32'h0,         3, 32'hDEADBEEF, 0, 0);
    xfer(0, 32'h0000_000C, 32'h0,         2, 32'h0000_1234, 0, 1);
    xfer(0, 32'h0000_0010, 32'h0,         0, 32'h0000_5678, 1, 0);
    xfer(1, 32'h0000_0014, 32'h0000_9999, 1, 32'hFFFF_0000, 1, 0);

    // Back-to-back with CMD_VALID held
    e.rdata = 0; e.err = 0; e.to = 0;
    sb.push_back(e); sb.push_back(e);
    CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'hA0; CMD_WDATA = 32'h11; PREADY = 1;
    step();                                   // first accept
    CMD_ADDR = 32'hA4; CMD_WDATA = 32'h22;
    chk("b2b_ready_low", CMD_READY, 0);
    step();
    chk("b2b_paddr_first", PADDR, 32'hA0);
    step();
    chk("b2b_rsp1", {RSP_VALID, CMD_READY}, 2'b11);
    step();                                   // second accept happened in RSP cycle
    CMD_VALID = 0;
    chk("b2b_psel2",   {PSELx, PENABLE}, 2'b10);
    chk("b2b_paddr2",  PADDR,  32'hA4);
    chk("b2b_pwdata2", PWDATA, 32'h22);
    step(); step();
    chk("b2b_rsp2", RSP_VALID, 1);
    PREADY = 0;
    step();

    // Reset mid-ACCESS
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h30; PREADY = 0;
    step();
    CMD_VALID = 0;
    step(); step();
    chk("pre_rst_access", PENABLE, 1);
    n = rsp_cnt;
    PRESET = 1;
    step();
    PRESET = 0; PREADY = 1;
    chk("midrst_psel",    {PSELx, PENABLE}, 2'b00);
    chk("midrst_ready",   CMD_READY, 1);
    chk("midrst_rsp",     RSP_VALID, 0);
    step(); step(); step();
    chk("midrst_no_rsp",  rsp_cnt, n);
    PREADY = 0;
    xfer(0, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D, 0, 0);

    // Timeout behaviour
    CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = 32'h20; PREADY = 0; PRDATA = 32'h7777_7777;
`ifdef APB_MASTER_TIMEOUT_EN
    e.rdata = 0; e.err = 1; e.to = 1;
    sb.push_back(e);
    step();
    CMD_VALID = 0;
    step(); step(); step(); step();
    chk("to_still_access", {PENABLE, RSP_VALID}, 2'b10);
    step();
    chk("to_abort", {RSP_VALID, PSELx, PENABLE, CMD_READY}, 4'b1001);
    step();
    // PREADY on the last allowed cycle completes normally
    xfer(0, 32'h0000_0024, 32'h0, 3, 32'h0BAD_CAFE, 0, 0);
`else
    n = rsp_cnt;
    step();
    CMD_VALID = 0;
    repeat (100) step();
    chk("nto_access", {PSELx, PENABLE, CMD_READY}, 3'b110);
    chk("nto_no_rsp", rsp_cnt, n);
    chk("nto_flag",   RSP_TIMEOUT, 0);
    PRESET = 1;
    step();
    PRESET = 0;
    step();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
